// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for PC, IF/ID, ID/EX; perf counters exist only with HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl #(
  parameter int CORE            = 0,
  parameter int FLUSH_CYCLES    = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int PERF_WIDTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic [1:0]            state_o,
  output logic [PERF_WIDTH-1:0] perf_stall_cycles,
  output logic [PERF_WIDTH-1:0] perf_flush_events,
  output logic [PERF_WIDTH-1:0] perf_load_use_events
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, LOAD_STALL = 2'd2, MEM_WAIT = 2'd3} state_t;
  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       lu, open, seq;
  assign lu = ex_is_load & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));
  // open: new hazards are accepted this cycle (RUN, or the MEM_WAIT release cycle)
  assign open    = ~dmem_busy & ((state == RUN) | (state == MEM_WAIT));
  assign seq     = ~dmem_busy & (state == LOAD_STALL);
  assign state_o = state;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    pc_stall    = dmem_busy | seq | (open & ~ex_redirect & lu);
    if_id_stall = pc_stall;
    id_ex_stall = dmem_busy;
    if_id_flush = ~dmem_busy & ((state == FLUSH) | (open & ex_redirect));
    id_ex_flush = if_id_flush | seq | (open & ~ex_redirect & lu);
    state_n     = state;
    cnt_n       = cnt;
    if (dmem_busy)
      state_n = (state == RUN) ? MEM_WAIT : state;
    else if (state == FLUSH || state == LOAD_STALL) begin
      cnt_n   = cnt - 3'd1;
      state_n = (cnt == 3'd1) ? RUN : state;
    end else if (ex_redirect) begin
      cnt_n   = 3'(FLUSH_CYCLES - 1);
      state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (lu) begin
      cnt_n   = 3'(LOAD_USE_CYCLES - 1);
      state_n = (LOAD_USE_CYCLES > 1) ? LOAD_STALL : RUN;
    end else
      state_n = RUN;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_WIDTH-1:0] stall_q, flush_q, lu_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      if (pc_stall && !(&stall_q)) stall_q <= stall_q + PERF_WIDTH'(1);
      if (open && ex_redirect && !(&flush_q)) flush_q <= flush_q + PERF_WIDTH'(1);
      if (open && !ex_redirect && lu && !(&lu_q)) lu_q <= lu_q + PERF_WIDTH'(1);
    end
  assign perf_stall_cycles    = stall_q;
  assign perf_flush_events    = flush_q;
  assign perf_load_use_events = lu_q;
`else
  assign perf_stall_cycles    = '0;
  assign perf_flush_events    = '0;
  assign perf_load_use_events = '0;
`endif
endmodule
